// File: rtl/bikers_pkg.sv
// Shared constants and types for the bikes layer: bike count, player slot, detector states.
package bikers_pkg;

  localparam int ENEMY_BIKES_COUNT = 8;
  localparam int PLAYER_BIKE_IDX   = ENEMY_BIKES_COUNT;
  localparam int BIKE_IDX_W        = (ENEMY_BIKES_COUNT > 1) ? $clog2(ENEMY_BIKES_COUNT) : 1;

  typedef enum logic {
    ARMED    = 1'b0,
    COOLDOWN = 1'b1
  } collision_state_e;

endpackage

// File: rtl/bikers_priority_encoder.sv
// Lowest-set-bit index of a vector; 0 when the vector is empty.
// Purely combinational, no latency and no flow control.
module bikers_priority_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top so the lowest set bit is the last to win.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bikers_collision_detector.sv
// Per-frame player/enemy overlap detector with frame-counted invulnerability cooldown.
// Report is registered one cycle after startOfFrame; no backpressure, runs every pixel.
module bikers_collision_detector #(
  parameter int ENEMY_BIKES_COUNT = bikers_pkg::ENEMY_BIKES_COUNT,
  parameter int COOLDOWN_FRAMES   = 60,
  localparam int IDX_W = (ENEMY_BIKES_COUNT > 1) ? $clog2(ENEMY_BIKES_COUNT) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic [ENEMY_BIKES_COUNT:0]   inputInsideRectangle,
  output logic                         collisionPulse,
  output logic [ENEMY_BIKES_COUNT-1:0] enemyHitMask,
  output logic [IDX_W-1:0]             collisionEnemyIndex,
  output logic                         invulnerable
);
  import bikers_pkg::*;

  localparam int PLAYER_IDX = ENEMY_BIKES_COUNT;
  localparam int CNT_W      = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  collision_state_e             state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [ENEMY_BIKES_COUNT-1:0] accum_q, accum_d;
  logic                         window_vld_q, window_vld_d;
  logic                         pulse_q, pulse_d;
  logic [ENEMY_BIKES_COUNT-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [ENEMY_BIKES_COUNT-1:0] hit_now;
  logic [IDX_W-1:0]             snap_idx;

  bikers_priority_encoder #(
    .WIDTH (ENEMY_BIKES_COUNT),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i (accum_q),
    .idx_o (snap_idx)
  );

  always_comb begin
    hit_now      = inputInsideRectangle[ENEMY_BIKES_COUNT-1:0]
                 & {ENEMY_BIKES_COUNT{inputInsideRectangle[PLAYER_IDX]}};
    state_d      = state_q;
    cnt_d        = cnt_q;
    accum_d      = accum_q | hit_now;
    window_vld_d = window_vld_q;
    pulse_d      = 1'b0;
    mask_d       = mask_q;
    idx_d        = idx_q;
    // The boundary pixel opens the new frame; accum_q still holds the old one.
    // A window is only trusted once a boundary has been seen since reset.
    if (startOfFrame) begin
      accum_d      = hit_now;
      window_vld_d = 1'b1;
      case (state_q)
        ARMED: begin
          if (window_vld_q && (accum_q != '0)) begin
            pulse_d = 1'b1;
            mask_d  = accum_q;
            idx_d   = snap_idx;
            if (COOLDOWN_FRAMES > 0) begin
              cnt_d   = CNT_W'(COOLDOWN_FRAMES);
              state_d = COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARMED;
      cnt_q        <= '0;
      accum_q      <= '0;
      window_vld_q <= 1'b0;
      pulse_q      <= 1'b0;
      mask_q       <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      accum_q      <= accum_d;
      window_vld_q <= window_vld_d;
      pulse_q      <= pulse_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
    end
  end

  assign collisionPulse      = pulse_q;
  assign enemyHitMask        = mask_q;
  assign collisionEnemyIndex = idx_q;
  assign invulnerable        = (state_q == COOLDOWN);

endmodule

// File: tb/tb_bikers_collision_detector.sv
// Directed bench: one detector with a 2-frame cooldown and one with cooldown disabled, shared stimulus.
module tb_bikers_collision_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0;
  logic [8:0] in_vec = '0;

  logic       a_pulse, a_inv, z_pulse, z_inv;
  logic [7:0] a_mask, z_mask;
  logic [2:0] a_idx, z_idx;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_a, exp_z;

  always #5 clk = ~clk;

  bikers_collision_detector #(.ENEMY_BIKES_COUNT(8), .COOLDOWN_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .inputInsideRectangle(in_vec),
    .collisionPulse(a_pulse), .enemyHitMask(a_mask), .collisionEnemyIndex(a_idx),
    .invulnerable(a_inv)
  );

  bikers_collision_detector #(.ENEMY_BIKES_COUNT(8), .COOLDOWN_FRAMES(0)) dut0 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .inputInsideRectangle(in_vec),
    .collisionPulse(z_pulse), .enemyHitMask(z_mask), .collisionEnemyIndex(z_idx),
    .invulnerable(z_inv)
  );

  // One pixel: drive, let the edge pass, leave outputs settled for sampling.
  task automatic px(input logic [8:0] v, input logic s);
    sof    = s;
    in_vec = v;
    @(posedge clk);
    #1;
    sof    = 1'b0;
  endtask

  task automatic body(input logic [8:0] v, input int n);
    for (int i = 0; i < n; i++) px(v, 1'b0);
  endtask

  task automatic test_reset;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({a_pulse, a_mask, a_idx, a_inv} !== 13'd0) begin
      errors++; $display("FAIL reset_a got %h want %h", {a_pulse, a_mask, a_idx, a_inv}, 13'd0);
    end
    checks++;
    if ({z_pulse, z_mask, z_idx, z_inv} !== 13'd0) begin
      errors++; $display("FAIL reset_z got %h want %h", {z_pulse, z_mask, z_idx, z_inv}, 13'd0);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    px(9'h000, 1'b1);
    checks++;
    if (a_pulse !== 1'b0) begin
      errors++; $display("FAIL first_boundary_pulse got %b want 0", a_pulse);
    end
    body(9'h108, 5);
    body(9'h000, 2);
    px(9'h000, 1'b1);
    exp_a = {1'b1, 8'h08, 3'd3, 1'b1};
    exp_z = {1'b1, 8'h08, 3'd3, 1'b0};
    checks++;
    if ({a_pulse, a_mask, a_idx, a_inv} !== exp_a) begin
      errors++; $display("FAIL single_a got %h want %h", {a_pulse, a_mask, a_idx, a_inv}, exp_a);
    end
    checks++;
    if ({z_pulse, z_mask, z_idx, z_inv} !== exp_z) begin
      errors++; $display("FAIL single_z got %h want %h", {z_pulse, z_mask, z_idx, z_inv}, exp_z);
    end
    px(9'h000, 1'b0);
    checks++;
    if ({a_pulse, a_mask, a_idx} !== {1'b0, 8'h08, 3'd3}) begin
      errors++; $display("FAIL single_hold got %h want %h", {a_pulse, a_mask, a_idx}, {1'b0, 8'h08, 3'd3});
    end
  endtask

  task automatic test_cooldown;
    body(9'h110, 3);
    px(9'h000, 1'b1);
    checks++;
    if ({a_pulse, a_inv} !== 2'b01) begin
      errors++; $display("FAIL cd_n1_a got %b want 01", {a_pulse, a_inv});
    end
    checks++;
    if ({z_pulse, z_mask, z_idx} !== {1'b1, 8'h10, 3'd4}) begin
      errors++; $display("FAIL b2b_z_1 got %h want %h", {z_pulse, z_mask, z_idx}, {1'b1, 8'h10, 3'd4});
    end
    body(9'h110, 3);
    px(9'h000, 1'b1);
    checks++;
    if ({a_pulse, a_inv} !== 2'b00) begin
      errors++; $display("FAIL cd_n2_a got %b want 00", {a_pulse, a_inv});
    end
    checks++;
    if (z_pulse !== 1'b1) begin
      errors++; $display("FAIL b2b_z_2 got %b want 1", z_pulse);
    end
    body(9'h110, 3);
    px(9'h000, 1'b1);
    exp_a = {1'b1, 8'h10, 3'd4, 1'b1};
    checks++;
    if ({a_pulse, a_mask, a_idx, a_inv} !== exp_a) begin
      errors++; $display("FAIL cd_n3_a got %h want %h", {a_pulse, a_mask, a_idx, a_inv}, exp_a);
    end
    body(9'h000, 2); px(9'h000, 1'b1);
    body(9'h000, 2); px(9'h000, 1'b1);
    checks++;
    if ({a_inv, z_pulse, z_inv} !== 3'b000) begin
      errors++; $display("FAIL cd_exit got %b want 000", {a_inv, z_pulse, z_inv});
    end
  endtask

  task automatic test_multi;
    px(9'h120, 1'b0); px(9'h000, 1'b0); px(9'h104, 1'b0); px(9'h000, 1'b0);
    px(9'h000, 1'b1);
    exp_a = {1'b1, 8'h24, 3'd2, 1'b1};
    checks++;
    if ({a_pulse, a_mask, a_idx, a_inv} !== exp_a) begin
      errors++; $display("FAIL multi_a got %h want %h", {a_pulse, a_mask, a_idx, a_inv}, exp_a);
    end
    checks++;
    if ({z_pulse, z_mask, z_idx} !== {1'b1, 8'h24, 3'd2}) begin
      errors++; $display("FAIL multi_z got %h want %h", {z_pulse, z_mask, z_idx}, {1'b1, 8'h24, 3'd2});
    end
    px(9'h000, 1'b0);
    checks++;
    if ({a_pulse, z_pulse} !== 2'b00) begin
      errors++; $display("FAIL multi_single_pulse got %b want 00", {a_pulse, z_pulse});
    end
    body(9'h000, 2); px(9'h000, 1'b1);
    body(9'h000, 2); px(9'h000, 1'b1);
  endtask

  task automatic test_sof_edge;
    body(9'h000, 3);
    px(9'h140, 1'b1);
    checks++;
    if ({a_pulse, z_pulse} !== 2'b00) begin
      errors++; $display("FAIL sof_edge_now got %b want 00", {a_pulse, z_pulse});
    end
    body(9'h000, 3);
    px(9'h000, 1'b1);
    checks++;
    if ({a_pulse, a_mask, a_idx} !== {1'b1, 8'h40, 3'd6}) begin
      errors++; $display("FAIL sof_edge_next_a got %h want %h", {a_pulse, a_mask, a_idx}, {1'b1, 8'h40, 3'd6});
    end
    checks++;
    if ({z_pulse, z_mask, z_idx} !== {1'b1, 8'h40, 3'd6}) begin
      errors++; $display("FAIL sof_edge_next_z got %h want %h", {z_pulse, z_mask, z_idx}, {1'b1, 8'h40, 3'd6});
    end
    body(9'h000, 2); px(9'h000, 1'b1);
    body(9'h000, 2); px(9'h000, 1'b1);
  endtask

  task automatic test_enemy_only;
    body(9'h012, 4);
    px(9'h012, 1'b1);
    checks++;
    if ({a_pulse, a_mask, a_inv} !== {1'b0, 8'h40, 1'b0}) begin
      errors++; $display("FAIL enemy_only_a got %h want %h", {a_pulse, a_mask, a_inv}, {1'b0, 8'h40, 1'b0});
    end
    checks++;
    if ({z_pulse, z_mask} !== {1'b0, 8'h40}) begin
      errors++; $display("FAIL enemy_only_z got %h want %h", {z_pulse, z_mask}, {1'b0, 8'h40});
    end
  endtask

  task automatic test_reset_mid;
    body(9'h108, 2);
    px(9'h000, 1'b1);
    checks++;
    if ({a_pulse, a_inv} !== 2'b11) begin
      errors++; $display("FAIL pre_reset_report got %b want 11", {a_pulse, a_inv});
    end
    body(9'h102, 3);
    reset = 1'b1;
    #1;
    checks++;
    if ({a_pulse, a_mask, a_idx, a_inv} !== 13'd0) begin
      errors++; $display("FAIL mid_reset_a got %h want %h", {a_pulse, a_mask, a_idx, a_inv}, 13'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    body(9'h102, 2);
    px(9'h000, 1'b1);
    checks++;
    if ({a_pulse, z_pulse, a_inv} !== 3'b000) begin
      errors++; $display("FAIL post_reset_boundary got %b want 000", {a_pulse, z_pulse, a_inv});
    end
    body(9'h180, 2);
    px(9'h000, 1'b1);
    exp_a = {1'b1, 8'h80, 3'd7, 1'b1};
    checks++;
    if ({a_pulse, a_mask, a_idx, a_inv} !== exp_a) begin
      errors++; $display("FAIL post_reset_report_a got %h want %h", {a_pulse, a_mask, a_idx, a_inv}, exp_a);
    end
    checks++;
    if ({z_pulse, z_mask, z_idx} !== {1'b1, 8'h80, 3'd7}) begin
      errors++; $display("FAIL post_reset_report_z got %h want %h", {z_pulse, z_mask, z_idx}, {1'b1, 8'h80, 3'd7});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cooldown();
    test_multi();
    test_sof_edge();
    test_enemy_only();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bikers_collision_detector.md
Name: bikers_collision_detector

Overview:
- Per-frame collision detector for the bikes layer. It consumes the same per-pixel inside-rectangle vector that feeds the bikes RGB mux: one bit per enemy bike, plus the player bike at the top index.
- It accumulates player/enemy pixel overlaps across a video frame and reports at most one collision event per frame boundary.
- After each report, an invulnerability cooldown suppresses further reports for a fixed number of frames. Its outputs drive game logic (life counter, sound) and a player blink effect.

Parameters:
- ENEMY_BIKES_COUNT, 8, number of enemy bikes; the player bit is index ENEMY_BIKES_COUNT.
- COOLDOWN_FRAMES, 60, frame boundaries ignored after a reported collision; 0 disables cooldown.

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- startOfFrame  input  1  one-cycle pulse on the first pixel of each frame
- inputInsideRectangle  input  ENEMY_BIKES_COUNT+1  per-pixel draw requests; bits [ENEMY_BIKES_COUNT-1:0] are enemies, bit [ENEMY_BIKES_COUNT] is the player
- collisionPulse  output  1  one-cycle pulse reporting a collision
- enemyHitMask  output  ENEMY_BIKES_COUNT  enemies that overlapped the player in the reported frame
- collisionEnemyIndex  output  $clog2(ENEMY_BIKES_COUNT)  lowest set index of enemyHitMask
- invulnerable  output  1  high while in COOLDOWN

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0.
  - Accumulator is cleared, cooldown counter is 0, state is ARMED.
  - Reset asserted mid-frame or mid-cooldown discards everything. The first report after reset needs a full startOfFrame-to-startOfFrame window.
- Per cycle: hitNow[i] = inputInsideRectangle[i] & inputInsideRectangle[ENEMY_BIKES_COUNT], for i < ENEMY_BIKES_COUNT.
- Accumulation:
  - When startOfFrame=0: accum <= accum | hitNow.
  - When startOfFrame=1: snapshot = accum (the previous frame only), then accum <= hitNow. The boundary pixel belongs to the new frame.
- Enemy-enemy overlaps are ignored. A player bit alone never sets anything.
- State ARMED, on startOfFrame:
  - If snapshot != 0: enemyHitMask <= snapshot, collisionEnemyIndex <= lowest set bit index, collisionPulse <= 1 for exactly one cycle (the cycle after startOfFrame).
  - Then, if COOLDOWN_FRAMES > 0: counter <= COOLDOWN_FRAMES and state -> COOLDOWN.
  - If COOLDOWN_FRAMES = 0, stay ARMED.
  - If snapshot == 0: no change.
- State COOLDOWN, on startOfFrame:
  - snapshot is discarded and counter decrements.
  - When the counter goes 1 -> 0, state -> ARMED, effective from the next boundary. Exactly COOLDOWN_FRAMES boundaries are ignored.
  - invulnerable = 1 throughout COOLDOWN, registered, asserted the cycle after the reporting boundary.
- enemyHitMask and collisionEnemyIndex hold their last reported values until the next report.
- collisionPulse is 0 in all other cycles. Back-to-back reports are possible only with COOLDOWN_FRAMES = 0, one per frame.
- Latency: startOfFrame to collisionPulse/mask valid is 1 cycle.
- Widths:
  - Counter width is max(1, $clog2(COOLDOWN_FRAMES+1)) and never underflows.
  - Index width for the default is 3 bits.

Decomposition:
- Package bikers_pkg holds ENEMY_BIKES_COUNT, PLAYER_BIKE_IDX (= ENEMY_BIKES_COUNT), the state enum {ARMED, COOLDOWN}, and the index width constant. The bikers mux and the enemy bike controllers share the package.
- One sub-module, bikers_priority_encoder: combinational lowest-set-bit index of an ENEMY_BIKES_COUNT-wide vector, output 0 when the vector is empty.

Test Plan:
- Reset, then frame with player bit plus enemy 3 overlapping for 5 pixels, then startOfFrame -> the next cycle has collisionPulse=1, enemyHitMask=8'b0000_1000, collisionEnemyIndex=3, invulnerable=1.
- Overlaps with enemies 5 and 2 in the same frame -> mask=8'b0010_0100, index=2, a single pulse.
- COOLDOWN_FRAMES=2: collision at boundary N, overlaps in every following frame:
  - boundaries N+1 and N+2 give no pulse;
  - invulnerable drops after N+2;
  - boundary N+3 pulses again.
- Overlap present only on the startOfFrame cycle itself -> no pulse at that boundary; pulse at the following boundary (mask shows that enemy).
- Enemy 1 and enemy 4 overlap each other with the player bit low for a whole frame -> no pulse, mask unchanged.
- Assert reset mid-COOLDOWN with a pending accumulated overlap -> outputs 0, ARMED; the next boundary gives no pulse; a fresh overlap frame then reports normally.
